// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Purpose:
//   Conditions raw, bouncy push-button inputs for the seven-segment display
//   stage. Each button is handled by its own fully independent datapath:
//     2-FF synchronizer -> counter-based debounce -> registered edge detect.
//
// Ports:
//   clk          in   1      sole clock, all logic on posedge
//   reset        in   1      synchronous, active-high reset
//   btn_raw      in   N_BTN  asynchronous, bouncy inputs (1 = pressed)
//   btn_level    out  N_BTN  debounced level
//   btn_press    out  N_BTN  1-cycle pulse per accepted press (and per
//                            auto-repeat when enabled)
//   btn_release  out  N_BTN  1-cycle pulse per accepted release
//
// Build option:
//   BTN_AUTO_REPEAT_EN - when defined, a held button produces an extra press
//   pulse REPEAT_DELAY cycles after the original press pulse, then one every
//   REPEAT_PERIOD cycles while the level stays 1. When undefined, no repeat
//   logic is built and the REPEAT_* parameters are unused.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int N_BTN         = 2,
  parameter int DEBOUNCE_CYC  = 250000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

`ifdef BTN_AUTO_REPEAT_EN
  localparam int              RP_MAX      = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                           : REPEAT_PERIOD;
  localparam int              RP_W        = $clog2(RP_MAX + 1);
  localparam logic [RP_W-1:0] RP_DLY_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_PER_LAST = RP_W'(REPEAT_PERIOD - 1);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic            s1_q, s2_q;
      logic            level_q, level_d;
      logic            press_q, press_d;
      logic            release_q, release_d;
      logic [DB_W-1:0] db_cnt_q, db_cnt_d;

      // Debounce: the count only survives consecutive disagreeing cycles, so
      // any bounce back to the current level restarts it from zero.
      always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (s2_q != level_q) begin
          if (db_cnt_q == DB_LAST) begin
            level_d = s2_q;
          end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
          end
        end
      end

`ifdef BTN_AUTO_REPEAT_EN
      logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;
      logic            rp_phase_q, rp_phase_d;  // 0: waiting for first repeat, 1: periodic
      logic            rp_fire;

      // Repeat only runs while the level was 1 and stays 1 this edge; the press
      // edge and the release edge both clear it, so no pulse lands on a release.
      always_comb begin
        rp_cnt_d   = rp_cnt_q;
        rp_phase_d = rp_phase_q;
        rp_fire    = 1'b0;
        if (!level_q || !level_d) begin
          rp_cnt_d   = '0;
          rp_phase_d = 1'b0;
        end else if (rp_cnt_q == (rp_phase_q ? RP_PER_LAST : RP_DLY_LAST)) begin
          rp_fire    = 1'b1;
          rp_cnt_d   = '0;
          rp_phase_d = 1'b1;
        end else begin
          rp_cnt_d = rp_cnt_q + RP_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rp_cnt_q   <= '0;
          rp_phase_q <= 1'b0;
        end else begin
          rp_cnt_q   <= rp_cnt_d;
          rp_phase_q <= rp_phase_d;
        end
      end

      assign press_d = (level_d & ~level_q) | rp_fire;
`else
      assign press_d = level_d & ~level_q;
`endif

      // Pulses are computed from the next level so they coincide with the
      // first cycle the new level is visible.
      assign release_d = ~level_d & level_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          s1_q      <= 1'b0;
          s2_q      <= 1'b0;
          level_q   <= 1'b0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
          db_cnt_q  <= '0;
        end else begin
          s1_q      <= btn_raw[gi];
          s2_q      <= s1_q;
          level_q   <= level_d;
          press_q   <= press_d;
          release_q <= release_d;
          db_cnt_q  <= db_cnt_d;
        end
      end

      assign btn_level[gi]   = level_q;
      assign btn_press[gi]   = press_q;
      assign btn_release[gi] = release_q;
    end
  endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Purpose:
//   Self-checking bench for button_conditioner (DEBOUNCE_CYC=4,
//   REPEAT_DELAY=10, REPEAT_PERIOD=5). A reference model predicts the
//   debounced level and the press/release events from the raw sample history;
//   predicted events are queued and a monitor pops and compares them whenever
//   the DUT pulses. Directed scenarios are followed by random stimulus.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int N   = 2;
  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RP  = 5;
  localparam int HMAX = 8192;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_press, btn_release;

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYC(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    int          btn;
    bit          rel;
  } ev_t;

  ev_t         expq[$];
  int unsigned cyc = 0;
  int          n_samp = 0;          // raw samples taken since last reset
  bit          samp [N][HMAX];
  bit          lvl  [N];
  int unsigned tpress [N];
  int          checks = 0;
  int          failures = 0;

  // Reference model: the level flips once the synchronized input (raw sampled
  // two edges earlier) has disagreed with it on DB consecutive edges.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      n_samp = 0;
      for (int b = 0; b < N; b++) lvl[b] = 1'b0;
    end else begin
      for (int b = 0; b < N; b++) samp[b][n_samp % HMAX] = btn_raw[b];
      n_samp++;
      for (int b = 0; b < N; b++) begin
        bit all_dis;
        all_dis = 1'b1;
        for (int j = 0; j < DB; j++) begin
          int idx;
          bit v;
          idx = n_samp - 3 - j;
          v   = (idx >= 0) ? samp[b][idx % HMAX] : 1'b0;
          if (v == lvl[b]) all_dis = 1'b0;
        end
        if (all_dis) begin
          lvl[b] = ~lvl[b];
          expq.push_back('{cyc: cyc, btn: b, rel: ~lvl[b]});
          if (lvl[b]) tpress[b] = cyc;
        end else if (AUTO && lvl[b]) begin
          int unsigned h;
          h = cyc - tpress[b];
          if (h == RD || (h > RD && ((h - RD) % RP) == 0))
            expq.push_back('{cyc: cyc, btn: b, rel: 1'b0});
        end
      end
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int b = 0; b < N; b++) begin
      checks++;
      if (btn_level[b] !== lvl[b]) begin
        failures++;
        $display("FAIL level cyc=%0d btn=%0d got=%b exp=%b", cyc, b, btn_level[b], lvl[b]);
      end
      checks++;
      if (btn_press[b] === 1'b1 && btn_release[b] === 1'b1) begin
        failures++;
        $display("FAIL overlap cyc=%0d btn=%0d press and release both 1, exp at most one", cyc, b);
      end
      for (int k = 0; k < 2; k++) begin
        bit pulse;
        pulse = (k == 0) ? (btn_press[b] === 1'b1) : (btn_release[b] === 1'b1);
        if (pulse) begin
          checks++;
          if (expq.size() == 0) begin
            failures++;
            $display("FAIL unexpected cyc=%0d btn=%0d %s got pulse, exp none", cyc, b,
                     (k == 0) ? "press" : "release");
          end else begin
            ev_t e;
            e = expq.pop_front();
            if (e.cyc != cyc || e.btn != b || e.rel != bit'(k)) begin
              failures++;
              $display("FAIL event got cyc=%0d btn=%0d rel=%0d exp cyc=%0d btn=%0d rel=%0d",
                       cyc, b, k, e.cyc, e.btn, e.rel);
            end else begin
              $display("cyc=%0d btn=%0d %s ok", cyc, b, (k == 0) ? "press" : "release");
            end
          end
        end
      end
    end
    // Anything still queued for this cycle or earlier was never produced.
    while (expq.size() > 0 && expq[0].cyc <= cyc) begin
      ev_t e;
      e = expq.pop_front();
      checks++;
      failures++;
      $display("FAIL missed got no pulse, exp cyc=%0d btn=%0d rel=%0d", e.cyc, e.btn, e.rel);
    end
  end

  task automatic drive(input logic rst, input logic [N-1:0] raw, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      reset   = rst;
      btn_raw = raw;
    end
  endtask

  initial begin
    int rem [N];
    logic [N-1:0] cur;

    // 1) both held through reset, then re-debounce to 11
    drive(1'b1, 2'b11, 3);
    drive(1'b0, 2'b11, 10);
    drive(1'b0, 2'b00, 10);
    // 2) short 3-cycle glitch on button 0
    drive(1'b0, 2'b01, 3);
    drive(1'b0, 2'b00, 10);
    // 3) bounce 1,0,1,1,0 then hold 1
    drive(1'b0, 2'b01, 1);
    drive(1'b0, 2'b00, 1);
    drive(1'b0, 2'b01, 2);
    drive(1'b0, 2'b00, 1);
    drive(1'b0, 2'b01, 10);
    // 4) release
    drive(1'b0, 2'b00, 10);
    // 5) reset mid-debounce
    drive(1'b0, 2'b01, 4);
    drive(1'b1, 2'b01, 1);
    drive(1'b0, 2'b01, 10);
    drive(1'b0, 2'b00, 10);
    // 6) long hold for auto-repeat
    drive(1'b0, 2'b01, 40);
    drive(1'b0, 2'b00, 10);

    // random bouncy stimulus with occasional resets
    cur = '0;
    for (int b = 0; b < N; b++) rem[b] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) begin
        if (rem[b] == 0) begin
          cur[b] = 1'($urandom_range(0, 1));
          rem[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40)
                                               : $urandom_range(1, 6);
        end
        rem[b]--;
      end
      drive(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, cur, 1);
    end
    drive(1'b0, 2'b00, 20);

    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending events, exp 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
